// File: rtl/mem_mfc_responder.sv
`default_nettype none
// ============================================================================
//  Module   : mem_mfc_responder
//  Purpose  : Memory-side responder for the MOV/MFC four-phase handshake.
//             Accepts a request, waits a programmable number of cycles,
//             performs one access on an internal big-endian byte RAM,
//             then raises mfc until the request is withdrawn.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    ADDR_W       byte-address width of the RAM (2**ADDR_W bytes)
//    WAIT_CYCLES  extra wait cycles between accept and completion (0..15)
//  Ports
//    clk         in   1   clock, rising edge
//    rst_n       in   1   asynchronous active-low reset
//    i_mov       in   1   request, held high until mfc is seen
//    i_rw        in   1   1 = read, 0 = write (sampled at accept)
//    i_size      in   2   00 byte, 01 half, 10 word, 11 reserved
//    i_addr      in   32  byte address (sampled at accept)
//    i_data_in   in   32  right-justified write data (sampled at accept)
//    o_data_out  out  32  right-justified, zero-extended read data
//    o_mfc       out  1   memory function complete
//    o_err       out  1   completed access was faulty
// ============================================================================
module mem_mfc_responder #(
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_mov,
  input  logic        i_rw,
  input  logic [1:0]  i_size,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_data_in,
  output logic [31:0] o_data_out,
  output logic        o_mfc,
  output logic        o_err
);

  localparam int                c_DEPTH = 1 << ADDR_W;
  localparam logic [3:0]        c_WAIT  = 4'(WAIT_CYCLES);
  localparam logic [ADDR_W-1:0] c_OFF1  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] c_OFF2  = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] c_OFF3  = ADDR_W'(3);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [3:0]  r_cnt;
  logic        r_rw;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic [31:0] r_dout;
  logic        r_err;
  logic [7:0]  r_mem [c_DEPTH];

  logic        w_accept;
  logic        w_complete;
  logic        w_hi_nz;
  logic        w_fault;
  logic        w_we;
  logic        w_re;
  logic [ADDR_W-1:0] w_a0;
  logic [ADDR_W-1:0] w_a1;
  logic [ADDR_W-1:0] w_a2;
  logic [ADDR_W-1:0] w_a3;
  logic [31:0] w_rdata;

  // Any address bit above the RAM range makes the access faulty.
  generate
    if (ADDR_W < 32) begin : g_hi_chk
      assign w_hi_nz = |r_addr[31:ADDR_W];
    end else begin : g_no_hi_chk
      assign w_hi_nz = 1'b0;
    end
  endgenerate

  assign w_fault = (r_size == 2'b11)
                 || ((r_size == 2'b01) && r_addr[0])
                 || ((r_size == 2'b10) && (r_addr[1:0] != 2'b00))
                 || w_hi_nz;

  assign w_accept   = (r_state == S_IDLE) && i_mov;
  assign w_complete = (r_state == S_WAIT) && i_mov && (r_cnt == 4'd0);
  assign w_we       = w_complete && !r_rw && !w_fault;
  assign w_re       = w_complete &&  r_rw && !w_fault;

  // Successful halfword/word accesses are aligned, so the following byte
  // addresses are formed by OR-ing in the offset (no carry possible).
  assign w_a0 = r_addr[ADDR_W-1:0];
  assign w_a1 = w_a0 | c_OFF1;
  assign w_a2 = w_a0 | c_OFF2;
  assign w_a3 = w_a0 | c_OFF3;

  always_comb begin
    w_rdata = 32'd0;
    case (r_size)
      2'b00:   w_rdata = {24'd0, r_mem[w_a0]};
      2'b01:   w_rdata = {16'd0, r_mem[w_a0], r_mem[w_a1]};
      default: w_rdata = {r_mem[w_a0], r_mem[w_a1], r_mem[w_a2], r_mem[w_a3]};
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and handshake output
  always_comb begin
    w_next = r_state;
    o_mfc  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_mov) begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        // Withdrawing the request while waiting aborts it without an access.
        if (!i_mov) begin
          w_next = S_IDLE;
        end else if (r_cnt == 4'd0) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        o_mfc = 1'b1;
        if (!i_mov) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Request latch, wait counter, completion status and read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= 4'd0;
      r_rw   <= 1'b0;
      r_size <= 2'b00;
      r_addr <= 32'd0;
      r_data <= 32'd0;
      r_dout <= 32'd0;
      r_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_rw   <= i_rw;
        r_size <= i_size;
        r_addr <= i_addr;
        r_data <= i_data_in;
        r_cnt  <= c_WAIT;
      end else if ((r_state == S_WAIT) && i_mov && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end

      if (w_complete) begin
        r_err <= w_fault;
      end else if ((r_state == S_DONE) && !i_mov) begin
        r_err <= 1'b0;
      end

      // Read data only moves on a successful read; writes and faults keep it.
      if (w_re) begin
        r_dout <= w_rdata;
      end
    end
  end

  // Byte RAM, big-endian: the most significant byte lives at the lowest address.
  always_ff @(posedge clk) begin
    if (w_we) begin
      case (r_size)
        2'b00: begin
          r_mem[w_a0] <= r_data[7:0];
        end
        2'b01: begin
          r_mem[w_a0] <= r_data[15:8];
          r_mem[w_a1] <= r_data[7:0];
        end
        2'b10: begin
          r_mem[w_a0] <= r_data[31:24];
          r_mem[w_a1] <= r_data[23:16];
          r_mem[w_a2] <= r_data[15:8];
          r_mem[w_a3] <= r_data[7:0];
        end
        default: begin
        end
      endcase
    end
  end

  assign o_data_out = r_dout;
  assign o_err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_mfc_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_mfc_responder
//  Purpose  : Self-checking bench for mem_mfc_responder. A transaction-level
//             reference (byte array plus expected handshake outputs) is
//             compared against the DUT on every falling edge; directed
//             literal checks pin the reference.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_mfc_responder;

  localparam int W0 = 2;
  localparam int AW = 9;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;

  // DUT 0 (WAIT_CYCLES = 2)
  logic        mov = 1'b0;
  logic        rw = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = 32'd0;
  logic [31:0] din = 32'd0;
  logic [31:0] dout;
  logic        mfc;
  logic        err;

  // DUT 1 (WAIT_CYCLES = 0)
  logic        mov1 = 1'b0;
  logic        rw1 = 1'b0;
  logic [1:0]  size1 = 2'b00;
  logic [31:0] addr1 = 32'd0;
  logic [31:0] din1 = 32'd0;
  logic [31:0] dout1;
  logic        mfc1;
  logic        err1;

  int n_vec = 0;
  int n_mis = 0;

  // Reference state for DUT 0
  logic [7:0]  ref_mem [1 << AW];
  logic        exp_mfc = 1'b0;
  logic        exp_err = 1'b0;
  logic [31:0] exp_dout = 32'd0;
  logic        cmp_en = 1'b0;

  mem_mfc_responder #(.ADDR_W(AW), .WAIT_CYCLES(W0)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_mov(mov), .i_rw(rw), .i_size(size),
    .i_addr(addr), .i_data_in(din), .o_data_out(dout), .o_mfc(mfc), .o_err(err)
  );

  mem_mfc_responder #(.ADDR_W(AW), .WAIT_CYCLES(0)) u_dut0w (
    .clk(clk), .rst_n(rst_n), .i_mov(mov1), .i_rw(rw1), .i_size(size1),
    .i_addr(addr1), .i_data_in(din1), .o_data_out(dout1), .o_mfc(mfc1), .o_err(err1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison of DUT 0 against the reference.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("mfc", {31'd0, mfc}, {31'd0, exp_mfc});
      check("err", {31'd0, err}, {31'd0, exp_err});
      check("data_out", dout, exp_dout);
    end
  end

  function automatic bit is_fault(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'b11) || (sz == 2'b01 && a % 2 != 0) ||
           (sz == 2'b10 && a % 4 != 0) || (a >= (32'd1 << AW));
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  // Reference effect of one completed access.
  task automatic model_apply(input bit r, input logic [1:0] sz, input logic [31:0] a,
                             input logic [31:0] d);
    int nb;
    logic [31:0] v;
    exp_mfc = 1'b1;
    exp_err = is_fault(sz, a);
    if (!exp_err) begin
      nb = nbytes(sz);
      if (r) begin
        v = 32'd0;
        for (int i = 0; i < nb; i++) v = (v << 8) | {24'd0, ref_mem[int'(a) + i]};
        exp_dout = v;
      end else begin
        for (int i = 0; i < nb; i++) ref_mem[int'(a) + i] = 8'(d >> (8 * (nb - 1 - i)));
      end
    end
  endtask

  // Full four-phase transaction on DUT 0; hold = extra edges mov stays high in DONE.
  task automatic access(input bit r, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] d, input int hold);
    @(posedge clk); #1;
    mov = 1'b1; rw = r; size = sz; addr = a; din = d;
    @(posedge clk); #1;
    // Accepted: scramble inputs, the latched copy must be used.
    rw = ~r; size = ~sz; addr = ~a; din = ~d;
    repeat (W0) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    model_apply(r, sz, a, d);
    repeat (hold) begin
      @(posedge clk); #1;
    end
    mov = 1'b0;
    @(posedge clk); #1;
    exp_mfc = 1'b0;
    exp_err = 1'b0;
  endtask

  // Request withdrawn k edges after acceptance (k <= W0): no access, no mfc.
  task automatic abort_req(input logic [31:0] a, input logic [31:0] d, input int k);
    @(posedge clk); #1;
    mov = 1'b1; rw = 1'b0; size = 2'b10; addr = a; din = d;
    @(posedge clk); #1;
    repeat (k) begin
      @(posedge clk); #1;
    end
    mov = 1'b0;
    @(posedge clk); #1;
  endtask

  // Transaction on the zero-wait DUT with literal latency checks.
  task automatic access1(input bit r, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] d);
    @(posedge clk); #1;
    mov1 = 1'b1; rw1 = r; size1 = sz; addr1 = a; din1 = d;
    @(posedge clk);
    @(negedge clk);
    check("w0 mfc after accept", {31'd0, mfc1}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("w0 mfc one edge later", {31'd0, mfc1}, 32'd1);
    check("w0 err", {31'd0, err1}, 32'd0);
    #1 mov1 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("w0 mfc after drop", {31'd0, mfc1}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // Power-on reset
    #2 rst_n = 1'b0;
    cmp_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset data_out", dout, 32'd0);
    check("reset mfc", {31'd0, mfc}, 32'd0);

    // Known background contents
    access(1'b0, 2'b10, 32'h20, 32'hCAFEF00D, 0);
    access(1'b0, 2'b10, 32'h00, 32'h01020304, 0);

    // Reset in the middle of WAIT of a word write
    @(posedge clk); #1;
    mov = 1'b1; rw = 1'b0; size = 2'b10; addr = 32'h20; din = 32'h11223344;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0; mov = 1'b0;
    exp_mfc = 1'b0; exp_err = 1'b0; exp_dout = 32'd0;
    @(negedge clk);
    check("reset mid-wait mfc", {31'd0, mfc}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    access(1'b1, 2'b10, 32'h20, 32'd0, 0);
    check("word @0x20 after aborted write", dout, 32'hCAFEF00D);

    // Word write, then byte/half reads
    access(1'b0, 2'b10, 32'h10, 32'hDEADBEEF, 0);
    access(1'b1, 2'b00, 32'h10, 32'd0, 0);
    check("byte @0x10", dout, 32'h000000DE);
    access(1'b1, 2'b00, 32'h13, 32'd0, 0);
    check("byte @0x13", dout, 32'h000000EF);
    access(1'b1, 2'b01, 32'h12, 32'd0, 0);
    check("half @0x12", dout, 32'h0000BEEF);

    // Byte write inside the word
    access(1'b0, 2'b00, 32'h11, 32'hFFFFFFA5, 0);
    access(1'b1, 2'b10, 32'h10, 32'd0, 0);
    check("word @0x10 after byte write", dout, 32'hDEA5BEEF);

    // Faulty accesses
    access(1'b1, 2'b10, 32'h11, 32'd0, 0);
    access(1'b1, 2'b01, 32'h13, 32'd0, 1);
    access(1'b1, 2'b11, 32'h10, 32'd0, 0);
    access(1'b1, 2'b00, 32'h200, 32'd0, 0);
    access(1'b0, 2'b10, 32'h11, 32'h99999999, 0);
    access(1'b0, 2'b01, 32'h13, 32'h7777, 0);
    access(1'b0, 2'b00, 32'h200, 32'hFF, 0);
    access(1'b0, 2'b00, 32'h8000_0000, 32'hEE, 0);
    check("data_out kept through faults", dout, 32'hDEA5BEEF);
    access(1'b1, 2'b10, 32'h00, 32'd0, 0);
    check("word @0x0 untouched", dout, 32'h01020304);
    access(1'b1, 2'b10, 32'h10, 32'd0, 0);
    check("word @0x10 untouched", dout, 32'hDEA5BEEF);

    // Handshake: long hold in DONE, aborts during WAIT
    access(1'b1, 2'b10, 32'h20, 32'd0, 5);
    abort_req(32'h10, 32'h55555555, 0);
    abort_req(32'h10, 32'h55555555, 1);
    abort_req(32'h10, 32'h55555555, W0);
    access(1'b1, 2'b10, 32'h10, 32'd0, 0);
    check("word @0x10 after aborts", dout, 32'hDEA5BEEF);
    access(1'b0, 2'b01, 32'h1E, 32'h0000C3C4, 3);
    access(1'b1, 2'b00, 32'h1F, 32'd0, 0);
    check("byte @0x1F", dout, 32'h000000C4);

    // Zero-wait instance
    access1(1'b0, 2'b00, 32'h05, 32'h00000077);
    access1(1'b1, 2'b00, 32'h05, 32'd0);
    check("w0 byte @0x5", dout1, 32'h00000077);
    access1(1'b0, 2'b10, 32'h08, 32'h01234567);
    access1(1'b1, 2'b01, 32'h0A, 32'd0);
    check("w0 half @0xA", dout1, 32'h00004567);

    repeat (2) @(posedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
